// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the CPU datapath: fetch, decode, per-opcode execute.
// Optional macro MEM_WAIT_EN adds mem_ready handshaking on the memory steps.
module control_unit #(
  parameter int unsigned CLEAR_CYCLES = 1,
  parameter logic [4:0]  ADD_OP       = 5'b00011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  input  logic [31:0] ir,
  output logic        run,
  output logic        clear,
  output logic [4:0]  opcode,
  output logic        PCout,
  output logic        MARin,
  output logic        incPC,
  output logic        read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin
);

  localparam int unsigned CW   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned NCTL = 23;

  localparam int unsigned I_PCOUT    = 0;
  localparam int unsigned I_MARIN    = 1;
  localparam int unsigned I_INCPC    = 2;
  localparam int unsigned I_READ     = 3;
  localparam int unsigned I_MDRIN    = 4;
  localparam int unsigned I_MDROUT   = 5;
  localparam int unsigned I_IRIN     = 6;
  localparam int unsigned I_WRITE    = 7;
  localparam int unsigned I_GRA      = 8;
  localparam int unsigned I_GRB      = 9;
  localparam int unsigned I_GRC      = 10;
  localparam int unsigned I_RIN      = 11;
  localparam int unsigned I_ROUT     = 12;
  localparam int unsigned I_BAOUT    = 13;
  localparam int unsigned I_COUT     = 14;
  localparam int unsigned I_YIN      = 15;
  localparam int unsigned I_ZIN      = 16;
  localparam int unsigned I_ZLOWOUT  = 17;
  localparam int unsigned I_ZHIGHOUT = 18;
  localparam int unsigned I_HIIN     = 19;
  localparam int unsigned I_LOIN     = 20;
  localparam int unsigned I_RUN      = 21;
  localparam int unsigned I_CLEAR    = 22;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  logic [3:0]      state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic [4:0]      op_q, op_d;
  logic [NCTL-1:0] ctl_q, ctl_d;
  logic [4:0]      opc_q, opc_d;

  logic mem_ok;
  logic is_alu, is_imm, is_ldi, is_ld, is_st, is_md, is_nn, is_halt, is_nop, is_eff;
  logic last_step, mem_step;
  logic [3:0] done_st;
  logic [4:0] imm_op;
  logic unused_ir_bits;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign unused_ir_bits = ^ir[26:0];

  // The opcode register loads on the T2->T3 edge; until then decode looks at the IR directly.
  assign op_d = (state_q == S_T2) ? ir[31:27] : op_q;

  assign is_alu  = (op_d >= 5'd3) && (op_d <= 5'd11);
  assign is_imm  = (op_d >= 5'd12) && (op_d <= 5'd14);
  assign is_ld   = (op_d == 5'd0);
  assign is_ldi  = (op_d == 5'd1);
  assign is_st   = (op_d == 5'd2);
  assign is_md   = (op_d == 5'd15) || (op_d == 5'd16);
  assign is_nn   = (op_d == 5'd17) || (op_d == 5'd18);
  assign is_halt = (op_d == 5'd27);
  assign is_eff  = is_ld | is_ldi | is_st;
  assign is_nop  = ~(is_alu | is_imm | is_eff | is_md | is_nn | is_halt);

  assign imm_op = (op_d == 5'd12) ? 5'b00011 :
                  (op_d == 5'd13) ? 5'b00101 : 5'b00110;

  assign last_step = (is_alu | is_imm | is_ldi) ? (state_q == S_T5) :
                     (is_ld | is_st)            ? (state_q == S_T7) :
                     is_md                      ? (state_q == S_T6) :
                     is_nn                      ? (state_q == S_T4) : 1'b1;

  assign mem_step = (state_q == S_T1) || (is_ld && (state_q == S_T6)) ||
                    (is_st && (state_q == S_T7));

  // A stop seen in the final step still halts at that boundary.
  assign done_st = (stop_pend_q | stop) ? S_HALT : S_T0;

  // Next state, then Moore controls decoded from the state being entered.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    stop_pend_d = stop_pend_q | stop;
    ctl_d       = '0;
    opc_d       = '0;

    case (state_q)
      S_RESET: begin
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) state_d = S_T0;
        else                                    clr_cnt_d = CW'(clr_cnt_q + CW'(1));
      end
      S_T0: state_d = S_T1;
      S_T1: if (mem_ok) state_d = S_T2;
      S_T2: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_nop) state_d = done_st;
        else             state_d = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (mem_step && !mem_ok) state_d = state_q;
        else if (last_step)      state_d = done_st;
        else                     state_d = 4'(state_q + 4'd1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    ctl_d[I_RUN] = (state_d != S_RESET) && (state_d != S_HALT);

    case (state_d)
      S_RESET: ctl_d[I_CLEAR] = 1'b1;
      S_T0: begin
        ctl_d[I_PCOUT] = 1'b1; ctl_d[I_MARIN] = 1'b1; ctl_d[I_INCPC] = 1'b1;
      end
      S_T1: begin
        ctl_d[I_READ] = 1'b1; ctl_d[I_MDRIN] = 1'b1;
      end
      S_T2: begin
        ctl_d[I_MDROUT] = 1'b1; ctl_d[I_IRIN] = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_imm) begin
          ctl_d[I_GRB] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_YIN] = 1'b1;
        end else if (is_eff) begin
          ctl_d[I_GRB] = 1'b1; ctl_d[I_BAOUT] = 1'b1; ctl_d[I_YIN] = 1'b1;
        end else if (is_md) begin
          ctl_d[I_GRA] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_YIN] = 1'b1;
        end else if (is_nn) begin
          ctl_d[I_GRB] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_ZIN] = 1'b1;
          opc_d = op_d;
        end
      end
      S_T4: begin
        if (is_alu) begin
          ctl_d[I_GRC] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_ZIN] = 1'b1;
          opc_d = op_d;
        end else if (is_imm) begin
          ctl_d[I_COUT] = 1'b1; ctl_d[I_ZIN] = 1'b1;
          opc_d = imm_op;
        end else if (is_eff) begin
          ctl_d[I_COUT] = 1'b1; ctl_d[I_ZIN] = 1'b1;
          opc_d = ADD_OP;
        end else if (is_md) begin
          ctl_d[I_GRB] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_ZIN] = 1'b1;
          opc_d = op_d;
        end else if (is_nn) begin
          ctl_d[I_ZLOWOUT] = 1'b1; ctl_d[I_GRA] = 1'b1; ctl_d[I_RIN] = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin
          ctl_d[I_ZLOWOUT] = 1'b1; ctl_d[I_GRA] = 1'b1; ctl_d[I_RIN] = 1'b1;
        end else if (is_ld || is_st) begin
          ctl_d[I_ZLOWOUT] = 1'b1; ctl_d[I_MARIN] = 1'b1;
        end else if (is_md) begin
          ctl_d[I_ZLOWOUT] = 1'b1; ctl_d[I_LOIN] = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          ctl_d[I_READ] = 1'b1; ctl_d[I_MDRIN] = 1'b1;
        end else if (is_st) begin
          ctl_d[I_GRA] = 1'b1; ctl_d[I_ROUT] = 1'b1; ctl_d[I_MDRIN] = 1'b1;
        end else if (is_md) begin
          ctl_d[I_ZHIGHOUT] = 1'b1; ctl_d[I_HIIN] = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          ctl_d[I_MDROUT] = 1'b1; ctl_d[I_GRA] = 1'b1; ctl_d[I_RIN] = 1'b1;
        end else if (is_st) begin
          ctl_d[I_WRITE] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_RESET;
      clr_cnt_q      <= '0;
      stop_pend_q    <= 1'b0;
      op_q           <= '0;
      ctl_q          <= '0;
      ctl_q[I_CLEAR] <= 1'b1;
      opc_q          <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      stop_pend_q <= stop_pend_d;
      op_q        <= op_d;
      ctl_q       <= ctl_d;
      opc_q       <= opc_d;
    end
  end

  assign opcode   = opc_q;
  assign PCout    = ctl_q[I_PCOUT];
  assign MARin    = ctl_q[I_MARIN];
  assign incPC    = ctl_q[I_INCPC];
  assign read     = ctl_q[I_READ];
  assign MDRin    = ctl_q[I_MDRIN];
  assign MDRout   = ctl_q[I_MDROUT];
  assign IRin     = ctl_q[I_IRIN];
  assign write    = ctl_q[I_WRITE];
  assign Gra      = ctl_q[I_GRA];
  assign Grb      = ctl_q[I_GRB];
  assign Grc      = ctl_q[I_GRC];
  assign Rin      = ctl_q[I_RIN];
  assign Rout     = ctl_q[I_ROUT];
  assign BAout    = ctl_q[I_BAOUT];
  assign Cout     = ctl_q[I_COUT];
  assign Yin      = ctl_q[I_YIN];
  assign Zin      = ctl_q[I_ZIN];
  assign ZLowOut  = ctl_q[I_ZLOWOUT];
  assign ZHighOut = ctl_q[I_ZHIGHOUT];
  assign HIin     = ctl_q[I_HIIN];
  assign LOin     = ctl_q[I_LOIN];
  assign run      = ctl_q[I_RUN];
  assign clear    = ctl_q[I_CLEAR];

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected control word per
// cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;

  localparam logic [22:0] PCOUT    = 23'(1) << 0;
  localparam logic [22:0] MARIN    = 23'(1) << 1;
  localparam logic [22:0] INCPC    = 23'(1) << 2;
  localparam logic [22:0] READ     = 23'(1) << 3;
  localparam logic [22:0] MDRIN    = 23'(1) << 4;
  localparam logic [22:0] MDROUT   = 23'(1) << 5;
  localparam logic [22:0] IRIN     = 23'(1) << 6;
  localparam logic [22:0] WRITE    = 23'(1) << 7;
  localparam logic [22:0] GRA      = 23'(1) << 8;
  localparam logic [22:0] GRB      = 23'(1) << 9;
  localparam logic [22:0] GRC      = 23'(1) << 10;
  localparam logic [22:0] RIN      = 23'(1) << 11;
  localparam logic [22:0] ROUT     = 23'(1) << 12;
  localparam logic [22:0] BAOUT    = 23'(1) << 13;
  localparam logic [22:0] COUT     = 23'(1) << 14;
  localparam logic [22:0] YIN      = 23'(1) << 15;
  localparam logic [22:0] ZIN      = 23'(1) << 16;
  localparam logic [22:0] ZLOWOUT  = 23'(1) << 17;
  localparam logic [22:0] ZHIGHOUT = 23'(1) << 18;
  localparam logic [22:0] HIIN     = 23'(1) << 19;
  localparam logic [22:0] LOIN     = 23'(1) << 20;
  localparam logic [22:0] RUN      = 23'(1) << 21;
  localparam logic [22:0] CLR      = 23'(1) << 22;
  localparam logic [22:0] HALTW    = 23'(0);

  localparam logic [22:0] F0 = RUN | PCOUT | MARIN | INCPC;
  localparam logic [22:0] F1 = RUN | READ | MDRIN;
  localparam logic [22:0] F2 = RUN | MDROUT | IRIN;

  typedef struct {
    logic [22:0] ctl;
    logic [4:0]  opc;
    string       tag;
  } exp_t;

  logic clock, reset, stop;
  logic [31:0] ir;
`ifdef MEM_WAIT_EN
  logic mem_ready;
`endif
  logic run, clear;
  logic [4:0] opcode;
  logic PCout, MARin, incPC, read, MDRin, MDRout, IRin, write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  control_unit #(.CLEAR_CYCLES(1), .ADD_OP(5'b00011)) dut (
    .clock(clock), .reset(reset), .stop(stop),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir(ir), .run(run), .clear(clear), .opcode(opcode),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .read(read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one expected word per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [22:0] act;
      e   = exp_q.pop_front();
      act = {clear, run, LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, Cout, BAout, Rout, Rin,
             Grc, Grb, Gra, write, IRin, MDRout, MDRin, read, incPC, MARin, PCout};
      n_tests++;
      if (act !== e.ctl || opcode !== e.opc) begin
        n_fail++;
        $display("FAIL %s: ctl=%06h opcode=%05b, expected ctl=%06h opcode=%05b",
                 e.tag, act, opcode, e.ctl, e.opc);
      end
    end
  end

  task automatic step(input logic [22:0] c, input logic [4:0] o, input string tag);
    exp_q.push_back('{ctl: c, opc: o, tag: tag});
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string t);
    step(F0, 5'd0, {t, "_T0"});
    step(F1, 5'd0, {t, "_T1"});
    step(F2, 5'd0, {t, "_T2"});
  endtask

  task automatic pulse_reset(input string t);
    reset = 1'b1;
    #1;
    step(CLR, 5'd0, {t, "_hold"});
    reset = 1'b0;
    step(CLR, 5'd0, {t, "_clr"});
  endtask

  initial begin
    reset = 1'b0;
    stop  = 1'b0;
    ir    = 32'h0;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(CLR, 5'd0, "rst_hold");
    reset = 1'b0;
    step(CLR, 5'd0, "rst_clr");

    // add R1,R2,R3
    ir = 32'h18918000;
    fetch("add");
    step(RUN | GRB | ROUT | YIN,     5'd0,     "add_T3");
    step(RUN | GRC | ROUT | ZIN,     5'b00011, "add_T4");
    step(RUN | ZLOWOUT | GRA | RIN,  5'd0,     "add_T5");

    // ld R2,0x95(R1)
    ir = 32'h01080095;
    fetch("ld");
    step(RUN | GRB | BAOUT | YIN,    5'd0,     "ld_T3");
    step(RUN | COUT | ZIN,           5'b00011, "ld_T4");
    step(RUN | ZLOWOUT | MARIN,      5'd0,     "ld_T5");
    step(RUN | READ | MDRIN,         5'd0,     "ld_T6");
    step(RUN | MDROUT | GRA | RIN,   5'd0,     "ld_T7");

    // st
    ir = 32'h10000090;
    fetch("st");
    step(RUN | GRB | BAOUT | YIN,    5'd0,     "st_T3");
    step(RUN | COUT | ZIN,           5'b00011, "st_T4");
    step(RUN | ZLOWOUT | MARIN,      5'd0,     "st_T5");
    step(RUN | GRA | ROUT | MDRIN,   5'd0,     "st_T6");
    step(RUN | WRITE,                5'd0,     "st_T7");

    // mul
    ir = 32'h7B100000;
    fetch("mul");
    step(RUN | GRA | ROUT | YIN,     5'd0,     "mul_T3");
    step(RUN | GRB | ROUT | ZIN,     5'b01111, "mul_T4");
    step(RUN | ZLOWOUT | LOIN,       5'd0,     "mul_T5");
    step(RUN | ZHIGHOUT | HIIN,      5'd0,     "mul_T6");

    // andi maps to AND
    ir = 32'h68000000;
    fetch("andi");
    step(RUN | GRB | ROUT | YIN,     5'd0,     "andi_T3");
    step(RUN | COUT | ZIN,           5'b00101, "andi_T4");
    step(RUN | ZLOWOUT | GRA | RIN,  5'd0,     "andi_T5");

    // ldi
    ir = 32'h08000000;
    fetch("ldi");
    step(RUN | GRB | BAOUT | YIN,    5'd0,     "ldi_T3");
    step(RUN | COUT | ZIN,           5'b00011, "ldi_T4");
    step(RUN | ZLOWOUT | GRA | RIN,  5'd0,     "ldi_T5");

    // neg
    ir = 32'h88000000;
    fetch("neg");
    step(RUN | GRB | ROUT | ZIN,     5'b10001, "neg_T3");
    step(RUN | ZLOWOUT | GRA | RIN,  5'd0,     "neg_T4");

    // nop and an undefined opcode both return straight to fetch
    ir = 32'hD0000000;
    fetch("nop");
    ir = 32'hF8000000;
    fetch("undef");

`ifdef MEM_WAIT_EN
    ir = 32'hD0000000;
    mem_ready = 1'b0;
    step(F0, 5'd0, "mw_T0");
    step(F1, 5'd0, "mw_T1a");
    step(F1, 5'd0, "mw_T1b");
    step(F1, 5'd0, "mw_T1c");
    mem_ready = 1'b1;
    step(F1, 5'd0, "mw_T1d");
    step(F2, 5'd0, "mw_T2");
`endif

    // stop raised during T4 of add: finish the instruction, then halt
    ir = 32'h18918000;
    fetch("stp");
    step(RUN | GRB | ROUT | YIN,     5'd0,     "stp_T3");
    stop = 1'b1;
    step(RUN | GRC | ROUT | ZIN,     5'b00011, "stp_T4");
    stop = 1'b0;
    step(RUN | ZLOWOUT | GRA | RIN,  5'd0,     "stp_T5");
    step(HALTW, 5'd0, "stp_halt0");
    step(HALTW, 5'd0, "stp_halt1");
    step(HALTW, 5'd0, "stp_halt2");

    // halt opcode
    pulse_reset("rst2");
    ir = 32'hD8000000;
    fetch("hlt");
    step(HALTW, 5'd0, "hlt_halt0");
    step(HALTW, 5'd0, "hlt_halt1");

    // reset during st T7 must drop write immediately
    pulse_reset("rst3");
    ir = 32'h10000090;
    fetch("abt");
    step(RUN | GRB | BAOUT | YIN,    5'd0,     "abt_T3");
    step(RUN | COUT | ZIN,           5'b00011, "abt_T4");
    step(RUN | ZLOWOUT | MARIN,      5'd0,     "abt_T5");
    step(RUN | GRA | ROUT | MDRIN,   5'd0,     "abt_T6");
    reset = 1'b1;
    #1;
    step(CLR, 5'd0, "abt_rst");
    reset = 1'b0;
    step(CLR, 5'd0, "abt_clr");
    step(F0, 5'd0, "abt_F0");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
